// File: rtl/cc_stack.sv
// LC-3 condition-code unit: N/Z/P (optionally C/V) flag register, registered
// branch-enable, and a bounded LIFO for saving cc across interrupt/trap entry.
module cc_stack #(
  parameter int unsigned W         = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned EXT_FLAGS = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [W-1:0]                 BUS,
  input  logic                         LD_CC,
  input  logic                         V_IN,
  input  logic                         C_IN,
  input  logic                         LD_BEN,
  input  logic [2:0]                   IR_NZP,
  input  logic                         PUSH,
  input  logic                         POP,
  input  logic                         CLR_ERR,
  output logic [W-1:0]                 nzp,
  output logic                         BEN,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int unsigned CCW  = (EXT_FLAGS != 0) ? 5 : 3;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CCW-1:0]  cc_q, cc_d, flags;
  logic [CCW-1:0]  stack_q [DEPTH];
  logic [CNTW-1:0] count_q, count_d;
  logic            ben_q, ben_d;
  logic            err_q, err_d;
  logic            push_only, pop_only, do_push, do_pop, new_err;
  logic [2:0]      nzp_flags;
  logic [IDXW-1:0] wr_idx, rd_idx;

  assign nzp_flags = (BUS == '0) ? 3'b010 :
                     BUS[W-1]    ? 3'b100 : 3'b001;

  generate
    if (EXT_FLAGS != 0) begin : g_ext
      assign flags = {C_IN, V_IN, nzp_flags};
    end else begin : g_base
      logic unused_ext;
      assign unused_ext = V_IN ^ C_IN;
      assign flags      = nzp_flags;
    end
  endgenerate

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);

  // Simultaneous PUSH and POP cancel: neither touches the stack nor flags an error.
  assign push_only = PUSH & ~POP;
  assign pop_only  = POP & ~PUSH;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;
  assign new_err   = (push_only & full) | (pop_only & empty);

  assign wr_idx = IDXW'(count_q);
  assign rd_idx = IDXW'(count_q - CNTW'(1));

  always_comb begin
    cc_d    = cc_q;
    count_d = count_q;
    ben_d   = ben_q;
    err_d   = err_q;

    if (do_pop) begin
      cc_d    = stack_q[rd_idx];
      count_d = count_q - CNTW'(1);
    end else if (LD_CC) begin
      cc_d = flags;
    end

    if (do_push) begin
      count_d = count_q + CNTW'(1);
    end

    if (LD_BEN) begin
      ben_d = |(IR_NZP & cc_q[2:0]);
    end

    if (new_err) begin
      err_d = 1'b1;
    end else if (CLR_ERR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cc_q    <= '0;
      count_q <= '0;
      ben_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      count_q <= count_d;
      ben_q   <= ben_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset; count alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (!Reset && do_push) begin
      stack_q[wr_idx] <= cc_q;
    end
  end

  assign nzp   = W'(cc_q);
  assign BEN   = ben_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: doc/cc_stack.md
# cc_stack

Parametrised condition-code unit for the LC-3 datapath. It generates N/Z/P flags (plus optional V/C) from the bus value and holds them in a register. It computes and registers the branch-enable (BEN) bit against IR[11:9]. It also provides a bounded save/restore stack so the control FSM can preserve condition codes across interrupt and trap entry and return.

## Interface
Parameters:
- W, default 16: bus width and `nzp` output width. Must be at least 5.
- DEPTH, default 4: number of condition-code entries the stack holds. Must be at least 1.
- EXT_FLAGS, default 0: 0 gives a 3-bit cc {N,Z,P}. 1 gives a 5-bit cc {C,V,N,Z,P}.

Ports:
- Clk, in, 1: single clock. All state changes on its rising edge.
- Reset, in, 1: synchronous, active-high.
- BUS, in, W: datapath bus value that the flags are derived from.
- LD_CC, in, 1: load the cc register from BUS (and from V_IN/C_IN when EXT_FLAGS=1).
- V_IN, in, 1: ALU overflow. Ignored when EXT_FLAGS=0.
- C_IN, in, 1: ALU carry. Ignored when EXT_FLAGS=0.
- LD_BEN, in, 1: register the branch-enable bit.
- IR_NZP, in, 3: IR[11:9] branch condition mask.
- PUSH, in, 1: save the current cc onto the stack.
- POP, in, 1: restore cc from the top of the stack.
- CLR_ERR, in, 1: clear the sticky error flag.
- nzp, out, W: cc register, zero-extended. Bits [2:0] are {N,Z,P}. Bits [4:3] are {C,V} when EXT_FLAGS=1.
- BEN, out, 1: registered branch-enable bit.
- count, out, $clog2(DEPTH+1): number of occupied stack entries.
- full, out, 1: asserted when count == DEPTH. Combinational from count.
- empty, out, 1: asserted when count == 0. Combinational from count.
- err, out, 1: sticky flag for stack overflow or underflow.

## Operation
Flag generation (combinational):
- BUS == 0 gives {N,Z,P} = 010.
- Otherwise BUS[W-1] == 1 gives 100.
- Otherwise the result is 001.
- With EXT_FLAGS=1, V and C are taken from V_IN and C_IN.

cc register update, in priority order:
1. Reset clears cc to 0.
2. POP with PUSH low and the stack not empty loads cc from the top entry.
3. LD_CC loads the generated flags.
4. Otherwise cc holds.

A valid POP overrides a simultaneous LD_CC.

Stack (LIFO, DEPTH entries, each cc-width bits):
- PUSH alone, not full: write the current (pre-edge) cc to the top and increment count.
- PUSH with LD_CC: the stack receives the old cc and the register takes the new flags.
- PUSH alone, when full: no write, count unchanged, set err.
- POP alone, when empty: cc unchanged, count unchanged, set err. LD_CC in the same cycle still applies.
- PUSH and POP together: the stack and count do not change and err is not set. cc follows LD_CC only.

err behaviour:
- err is sticky.
- It is cleared by Reset, or by CLR_ERR when no new error occurs in the same cycle.
- A new error in the same cycle as CLR_ERR wins, so err stays 1.

BEN:
- On LD_BEN, BEN <= |(IR_NZP & cc[2:0]), using the pre-edge cc.
- V and C never affect BEN.
- BEN holds when LD_BEN is low.

Reset values:
- nzp = 0 (no flag set, so a branch evaluated immediately after reset is not taken).
- BEN = 0, count = 0, err = 0.
- empty = 1, full = 0.
- Stack storage contents are don't-care.
- Reset asserted mid-sequence discards all stack contents.

## Timing
- All outputs are registered, except full and empty, which decode count combinationally.
- LD_CC at edge k: nzp reflects BUS after edge k. Latency is 1 cycle.
- LD_BEN at edge k uses cc as it was before edge k. To branch on freshly loaded flags, assert LD_CC at edge k and LD_BEN at edge k+1 (LC-3 BEN-after-CC ordering).
- PUSH at edge k followed by POP at edge k+1 restores the pushed value. Back-to-back operations every cycle are legal.
- There is no handshake. Commands are single-cycle strobes that act on every asserted edge.
- Stack pointer arithmetic never wraps. It saturates at 0 and DEPTH, with err reporting the refused operation.

## Test plan
- Flag decode, W=16: LD_CC with BUS = 0x0000, 0x8001, 0x7FFF on consecutive edges. nzp must read 0x0002, 0x0004, 0x0001, each one cycle after its edge.
- BEN ordering: cc = 100 (after BUS = 0x8000). Then LD_CC with BUS = 0x0005 and LD_BEN with IR_NZP = 100 on the same edge gives BEN = 1. LD_BEN again on the next edge gives BEN = 0. IR_NZP = 111 with cc = 0 after reset gives BEN = 0.
- Save/restore, DEPTH=4: load cc to 001 and PUSH, then 010 and PUSH, then 100. Two POPs must give nzp = 0x0002 then 0x0001, with count going 2→1→0 and empty asserting after the second pop.
- Overflow and underflow: push 5 times with DEPTH=4. count stays at 4, full = 1, err = 1 from the 5th push onward. Pop 5 times: the 5th pop sets err (after a CLR_ERR), and nzp is unchanged by that pop.
- Simultaneous events:
  - PUSH + LD_CC (cc = 001, BUS = 0): the stack top becomes 001 and nzp becomes 0x0002.
  - POP + LD_CC: nzp takes the popped value.
  - PUSH + POP: count unchanged, no error.
  - CLR_ERR + underflow: err stays 1.
- Mid-operation reset with EXT_FLAGS=1: after 3 pushes with V_IN = C_IN = 1 loaded (nzp = 0x001x), assert Reset for one cycle. All outputs must return to reset values, and a following POP must set err.
